icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between fetch/datapath and the memory controller's instruction port.
- 16 frames, one word per block, using the icachef_t split: tag[31:6], idx[5:2], bytoff[1:0].
- Serves hits combinationally in the same cycle.
- On a miss, fetches one word from memory, fills the frame, then serves the hit.

Parameters:
- CNT_W, 32: width of the hit and miss performance counters.
- Geometry is not configurable. It is fixed by cpu_types_pkg: ITAG_W=26, IIDX_W=4, IBLK_W=0, IBYT_W=2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32 (word_t)  datapath instruction byte address.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32 (word_t)  instruction word.
- iREN  out  1  memory-side read request.
- iaddr  out  32 (word_t)  memory-side word address.
- iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32 (word_t)  memory read data.
- hit_count  out  CNT_W  number of cycles with ihit=1.
- miss_count  out  CNT_W  number of misses, counted at entry to FETCH.

Behaviour:
- Storage: 16 frames, each {valid, tag[25:0], data[31:0]}. The index is imemaddr[5:2]. bytoff is ignored; iaddr is always imemaddr with bits [1:0] forced to 0.
- Hit condition (combinational): hit = imemREN & state==IDLE & frame[idx].valid & frame[idx].tag==imemaddr[31:6].
- Outputs:
  - ihit = hit.
  - imemload = frame[idx].data when hit, else 32'h0.
- State machine: two states, IDLE and FETCH.
- IDLE:
  - iREN=0 and iaddr=0.
  - If imemREN=1 and there is no hit, latch the miss address into an internal register (bits [1:0] zeroed), increment miss_count, and go to FETCH on the next edge.
  - If imemREN=0, no action.
- FETCH:
  - iREN=1, iaddr=latched address, ihit=0.
  - While iwait=1, stay in FETCH.
  - When iwait=0, on that edge:
    - write frame[latched idx] with valid=1, tag=latched tag, data=iload;
    - return to IDLE.
  - The fill uses the latched address even if imemaddr or imemREN changes during FETCH; a redirected fetch simply misses or hits afterwards.
- Latency:
  - Hit: 0 cycles (same cycle).
  - Miss: 1 cycle to enter FETCH, plus N wait cycles, then ihit in the first IDLE cycle after the fill if imemaddr is unchanged. With iwait low on the first FETCH cycle, ihit is first asserted 2 cycles after the miss cycle.
- Conflicts: a fill overwrites the resident frame unconditionally. There is no write-back; the icache is read-only.
- Counters:
  - hit_count increments on each cycle with ihit=1.
  - Both counters wrap modulo 2^CNT_W.
- Reset (RST=1, asynchronous):
  - All valid bits 0, state IDLE, latched address 0, both counters 0.
  - Therefore ihit=0, imemload=0, iREN=0, iaddr=0.
  - Tag and data arrays need not be reset.
- Reset during FETCH: abort immediately, iREN drops asynchronously, no frame is written, return to IDLE with all frames invalid.
- An iload arriving with iwait=0 while iREN=0 is ignored.

Test Plan:
- Reset then read: RST pulse, then imemREN=1, imemaddr=0x0000_0000 -> ihit=0. Next cycle iREN=1, iaddr=0x0, miss_count=1. Memory returns 0x2001_0005 with iwait=0 on the first FETCH cycle -> the following cycle ihit=1, imemload=0x2001_0005, hit_count=1.
- Hit reuse: read 0x0000_0004 (miss, fill 0xAAAA_0001), then re-read 0x0000_0004 -> ihit=1 in the same cycle, iREN stays 0, miss_count unchanged.
- Byte offset ignored: after filling 0x0000_0008, read 0x0000_000B -> hit, same data.
- Conflict eviction: fill 0x0000_0000 with 0x1111_1111, then read 0x0000_0040 (same idx 0, tag 1) -> miss and fill with 0x2222_2222. Re-reading 0x0000_0000 -> miss again, miss_count=3.
- Wait states and redirect: miss on 0x0000_0010 with iwait held high for 5 cycles -> iREN/iaddr=0x10 stable for all 6 FETCH cycles. Changing imemaddr to 0x0000_0020 mid-fetch does not change iaddr; frame 4 is filled.
- Reset mid-fetch: assert RST during FETCH with iwait=1 -> iREN=0 immediately. After release, a read of the same address misses again; counters are 0 before it.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
//   Direct-mapped, read-only instruction cache. It has 16 one-word frames and
//   sits between the fetch path and the memory controller's instruction port.
//   Hits are served combinationally in the request cycle. A miss latches the
//   word address and issues one memory read (FETCH state). When iwait drops,
//   the returned word fills the frame, and the request then hits in IDLE.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   imemREN, imemaddr   datapath read request and byte address
//   ihit, imemload      hit indication and instruction word (0 when no hit)
//   iREN, iaddr         memory-side read request and word address
//   iwait, iload        memory busy flag and read data
//   hit_count           count of cycles with ihit=1 (wraps)
//   miss_count          count of misses, taken on entry to FETCH (wraps)
// -----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    // Cache geometry is fixed: 26-bit tag, 4-bit index, one word per block.
    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IBYT_W  = 2;
    localparam int NFRAMES = 1 << IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_q;
    icachef_t           miss_q;     // latched miss address, bytoff always 0
    logic [NFRAMES-1:0] valid_q;
    logic [ITAG_W-1:0]  tag_q  [NFRAMES];
    logic [31:0]        data_q [NFRAMES];

    icachef_t req;
    logic     hit;
    logic     miss;
    logic     fill;

    assign req  = icachef_t'(imemaddr);
    assign hit  = imemREN && (state_q == IDLE) && valid_q[req.idx]
                  && (tag_q[req.idx] == req.tag);
    assign miss = imemREN && (state_q == IDLE) && !hit;
    // A fill happens only in FETCH. An iload that arrives while idle is ignored.
    assign fill = (state_q == FETCH) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data_q[req.idx] : '0;
    // The request comes straight from the state flop. Reset therefore drops
    // iREN asynchronously.
    assign iREN     = (state_q == FETCH);
    assign iaddr    = iREN ? 32'(miss_q) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            miss_q     <= '0;
            valid_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        miss_q     <= '{tag: req.tag, idx: req.idx, bytoff: '0};
                        miss_count <= miss_count + CNT_W'(1);
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid_q[miss_q.idx] <= 1'b1;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (hit) hit_count <= hit_count + CNT_W'(1);
        end
    end

    // The tag and data arrays are qualified by valid_q, so they need no reset.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_q.idx]  <= miss_q.tag;
            data_q[miss_q.idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
module tb_icache_direct_mapped;
    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_direct_mapped #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic pulse_reset();
        @(posedge CLK); #1;
        RST = 1'b1; imemREN = 1'b0; iwait = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // Issue one read. A miss is served by a memory model with 'waits' busy
    // cycles. redir_at >= 0 changes imemaddr during that FETCH cycle.
    task automatic read_word(input logic [31:0] addr, input bit exp_hit,
                             input logic [31:0] data, input int waits,
                             input int redir_at, input logic [31:0] redir_addr);
        logic [31:0] exp_d;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = addr;
        exp_q.push_back(data);
        @(negedge CLK);
        tests++;
        if (ihit !== exp_hit)
            $display("FAIL req_hit addr=%h: got ihit=%b expected %b", addr, ihit, exp_hit);
        tests++;
        if (hit_count !== exp_hits || miss_count !== exp_misses)
            $display("FAIL counters addr=%h: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     addr, hit_count, miss_count, exp_hits, exp_misses);
        if (hit_count !== exp_hits || miss_count !== exp_misses || ihit !== exp_hit) fails++;
        if (exp_hit) begin
            exp_d = exp_q.pop_front();
            tests++;
            if (imemload !== exp_d || iREN !== 1'b0) begin
                fails++;
                $display("FAIL hit_data addr=%h: got data=%h iREN=%b expected data=%h iREN=0",
                         addr, imemload, iREN, exp_d);
            end
            exp_hits++;
        end else begin
            exp_misses++;
            for (int w = 0; w <= waits; w++) begin
                @(posedge CLK); #1;
                iwait = (w < waits);
                iload = (w == waits) ? data : 32'hDEAD_BEEF;
                if (w == redir_at) imemaddr = redir_addr;
                @(negedge CLK);
                tests++;
                if (iREN !== 1'b1 || iaddr !== waddr || ihit !== 1'b0 || miss_count !== exp_misses) begin
                    fails++;
                    $display("FAIL fetch addr=%h cyc=%0d: got iREN=%b iaddr=%h ihit=%b miss=%0d expected 1 %h 0 %0d",
                             addr, w, iREN, iaddr, ihit, miss_count, waddr, exp_misses);
                end
            end
            @(posedge CLK); #1;
            iwait = 1'b0; iload = 32'hBAD0_0000;
            if (redir_at >= 0) begin
                imemREN = 1'b0;
                void'(exp_q.pop_front());
                @(negedge CLK);
                tests++;
                if (ihit !== 1'b0 || iREN !== 1'b0) begin
                    fails++;
                    $display("FAIL redir_idle: got ihit=%b iREN=%b expected 0 0", ihit, iREN);
                end
            end else begin
                @(negedge CLK);
                exp_d = exp_q.pop_front();
                tests++;
                if (ihit !== 1'b1 || imemload !== exp_d || iREN !== 1'b0 || iaddr !== 32'h0) begin
                    fails++;
                    $display("FAIL fill_hit addr=%h: got ihit=%b data=%h iREN=%b iaddr=%h expected 1 %h 0 0",
                             addr, ihit, imemload, iREN, iaddr, exp_d);
                end
                exp_hits++;
            end
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        tests++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0 ||
            hit_count !== 32'h0 || miss_count !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: got ihit=%b load=%h iREN=%b iaddr=%h hc=%0d mc=%0d expected all 0",
                     ihit, imemload, iREN, iaddr, hit_count, miss_count);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_first_read();
        read_word(32'h0000_0000, 1'b0, 32'h2001_0005, 0, -1, 32'h0);
        @(negedge CLK);
        tests++;
        if (hit_count !== 32'd1) begin
            fails++;
            $display("FAIL first_hit_count: got %0d expected 1", hit_count);
        end
    endtask

    task automatic test_hit_reuse();
        read_word(32'h0000_0004, 1'b0, 32'hAAAA_0001, 0, -1, 32'h0);
        read_word(32'h0000_0004, 1'b1, 32'hAAAA_0001, 0, -1, 32'h0);
        @(negedge CLK);
        tests++;
        if (miss_count !== 32'd2) begin
            fails++;
            $display("FAIL reuse_miss_count: got %0d expected 2", miss_count);
        end
    endtask

    task automatic test_byte_offset();
        read_word(32'h0000_0008, 1'b0, 32'h3333_0008, 1, -1, 32'h0);
        read_word(32'h0000_000B, 1'b1, 32'h3333_0008, 0, -1, 32'h0);
    endtask

    task automatic test_conflict();
        pulse_reset();
        read_word(32'h0000_0000, 1'b0, 32'h1111_1111, 0, -1, 32'h0);
        read_word(32'h0000_0040, 1'b0, 32'h2222_2222, 2, -1, 32'h0);
        read_word(32'h0000_0000, 1'b0, 32'h1111_1111, 0, -1, 32'h0);
        @(negedge CLK);
        tests++;
        if (miss_count !== 32'd3) begin
            fails++;
            $display("FAIL conflict_miss_count: got %0d expected 3", miss_count);
        end
    endtask

    task automatic test_redirect();
        read_word(32'h0000_0010, 1'b0, 32'h4444_0010, 5, 2, 32'h0000_0020);
        read_word(32'h0000_0010, 1'b1, 32'h4444_0010, 0, -1, 32'h0);
        read_word(32'h0000_0020, 1'b0, 32'h5555_0020, 0, -1, 32'h0);
    endtask

    task automatic test_reset_mid_fetch();
        @(posedge CLK); #1;
        imemREN = 1'b1; imemaddr = 32'h0000_0024; iwait = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        tests++;
        if (iREN !== 1'b1) begin
            fails++;
            $display("FAIL rst_fetch_pre: got iREN=%b expected 1", iREN);
        end
        #2 RST = 1'b1;
        #1;
        tests++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            fails++;
            $display("FAIL rst_async_drop: got iREN=%b iaddr=%h expected 0 0", iREN, iaddr);
        end
        @(posedge CLK); #1;
        RST = 1'b0; imemREN = 1'b0; iwait = 1'b0;
        exp_q.delete(); exp_hits = 0; exp_misses = 0;
        @(negedge CLK);
        tests++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            fails++;
            $display("FAIL rst_counters: got hc=%0d mc=%0d expected 0 0", hit_count, miss_count);
        end
        read_word(32'h0000_0024, 1'b0, 32'h6666_0024, 0, -1, 32'h0);
        // A frame filled before the reset must now be invalid.
        read_word(32'h0000_0010, 1'b0, 32'h7777_0010, 1, -1, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int i = 0; i < 16; i++)
            read_word(32'h0000_0100 + 32'(i * 4), 1'b0, 32'hC0DE_0000 | 32'(i), i % 3, -1, 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK); #1;
            imemREN = 1'b1; imemaddr = 32'h0000_0100 + 32'(i * 4) + 32'(i % 4);
            exp_q.push_back(32'hC0DE_0000 | 32'(i));
            @(negedge CLK);
            exp_d = exp_q.pop_front();
            tests++;
            if (ihit !== 1'b1 || imemload !== exp_d || iREN !== 1'b0) begin
                fails++;
                $display("FAIL b2b_hit i=%0d: got ihit=%b data=%h iREN=%b expected 1 %h 0",
                         i, ihit, imemload, iREN, exp_d);
            end
            exp_hits++;
        end
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        tests++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            fails++;
            $display("FAIL b2b_counters: got hc=%0d mc=%0d expected %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0;
        iwait = 1'b0; iload = 32'h0;
        test_reset();
        test_first_read();
        test_hit_reuse();
        test_byte_offset();
        test_conflict();
        test_redirect();
        test_reset_mid_fetch();
        pulse_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
